// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the multi-channel PWM core.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_PRESC_W = 8;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Bit offset of channel idx inside the packed duty bus.
  function automatic int duty_lsb(input int idx, input int cnt_w);
    return idx * cnt_w;
  endfunction

endpackage

// File: rtl/pwm_multi_core_if.sv
// Register-side bundle of the PWM core: configuration in, waveforms and status out.
interface pwm_multi_core_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int PRESC_W  = 8
);
  import pwm_pkg::*;

  // load is a one-cycle strobe with no back-pressure: it is accepted in every cycle it is high,
  // and a later strobe before the period boundary replaces the earlier captured set.
  logic                      enable;
  logic [PRESC_W-1:0]        prescale;
  logic [CNT_W-1:0]          period;
  logic [CHANNELS*CNT_W-1:0] duty;
  logic                      center_mode;
  logic [CHANNELS-1:0]       polarity;
  logic                      load;
  logic [CHANNELS-1:0]       pwm_out;
  logic                      period_tick;
  logic                      load_pending;
  logic [CNT_W-1:0]          dbg_cnt;
  dir_e                      dbg_dir;

  modport master (
    output enable, prescale, period, duty, center_mode, polarity, load,
    input  pwm_out, period_tick, load_pending, dbg_cnt, dbg_dir
  );

  modport slave (
    input  enable, prescale, period, duty, center_mode, polarity, load,
    output pwm_out, period_tick, load_pending, dbg_cnt, dbg_dir
  );

endinterface

// File: rtl/pwm_prescaler.sv
// Clock divider: one-cycle tick every prescale+1 enabled clocks, restarting from zero on enable.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;

  // >= rather than == so a live decrease of prescale cannot strand the counter above it.
  always_comb begin
    tick        = enable && (presc_cnt_q >= prescale);
    presc_cnt_d = (!enable || tick) ? '0 : presc_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) presc_cnt_q <= '0;
    else       presc_cnt_q <= presc_cnt_d;
  end

endmodule

// File: rtl/pwm_multi_core.sv
// N-channel PWM with shared prescaler/counter, edge or centre alignment and boundary-synchronised reloads.
module pwm_multi_core
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PRESC_W  = DEF_PRESC_W
) (
  input  logic            clk,
  input  logic            reset,
  pwm_multi_core_if.slave bus
);

  logic                      tick;
  logic                      wrap, boundary;
  logic [CNT_W-1:0]          cnt_q, cnt_nx;
  dir_e                      dir_q, dir_nx;
  logic [CNT_W-1:0]          per_a_q, per_p_q;
  logic [CHANNELS*CNT_W-1:0] duty_a_q, duty_p_q;
  logic                      mode_a_q, mode_p_q;
  logic                      load_pending_q;
  logic [CHANNELS-1:0]       pwm_q, raw;
  logic                      tick_q;

  pwm_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (bus.enable),
    .prescale (bus.prescale),
    .tick     (tick)
  );

  // Counter successor for the next tick; wrap marks the step that closes a period.
  always_comb begin
    cnt_nx = cnt_q;
    dir_nx = dir_q;
    wrap   = 1'b0;
    if (per_a_q == '0) begin
      cnt_nx = '0;
      dir_nx = DIR_UP;
      wrap   = 1'b1;
    end else if (mode_a_q == MODE_EDGE) begin
      dir_nx = DIR_UP;
      if (cnt_q >= per_a_q) begin
        cnt_nx = '0;
        wrap   = 1'b1;
      end else begin
        cnt_nx = cnt_q + 1'b1;
      end
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= per_a_q) begin
        cnt_nx = per_a_q - 1'b1;
        if (per_a_q == CNT_W'(1)) begin
          wrap = 1'b1;
        end else begin
          dir_nx = DIR_DOWN;
        end
      end else begin
        cnt_nx = cnt_q + 1'b1;
      end
    end else begin
      if (cnt_q <= CNT_W'(1)) begin
        cnt_nx = '0;
        dir_nx = DIR_UP;
        wrap   = 1'b1;
      end else begin
        cnt_nx = cnt_q - 1'b1;
      end
    end
    boundary = tick && wrap;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
    assign raw[i] = cnt_q < duty_a_q[duty_lsb(i, CNT_W) +: CNT_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      per_a_q        <= '0;
      duty_a_q       <= '0;
      mode_a_q       <= MODE_EDGE;
      per_p_q        <= '0;
      duty_p_q       <= '0;
      mode_p_q       <= MODE_EDGE;
      load_pending_q <= 1'b0;
      pwm_q          <= '0;
      tick_q         <= 1'b0;
    end else begin
      pwm_q <= bus.enable ? (raw ^ bus.polarity) : bus.polarity;
      if (!bus.enable) begin
        cnt_q  <= '0;
        dir_q  <= DIR_UP;
        tick_q <= 1'b0;
        // Nothing is running, so a load can take effect immediately.
        if (bus.load) begin
          per_a_q        <= bus.period;
          duty_a_q       <= bus.duty;
          mode_a_q       <= bus.center_mode;
          load_pending_q <= 1'b0;
        end
      end else begin
        tick_q <= boundary;
        if (tick) begin
          cnt_q <= cnt_nx;
          dir_q <= dir_nx;
        end
        if (boundary) begin
          load_pending_q <= 1'b0;
          if (bus.load) begin
            per_a_q  <= bus.period;
            duty_a_q <= bus.duty;
            mode_a_q <= bus.center_mode;
          end else if (load_pending_q) begin
            per_a_q  <= per_p_q;
            duty_a_q <= duty_p_q;
            mode_a_q <= mode_p_q;
          end
        end else if (bus.load) begin
          per_p_q        <= bus.period;
          duty_p_q       <= bus.duty;
          mode_p_q       <= bus.center_mode;
          load_pending_q <= 1'b1;
        end
      end
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_tick  = tick_q;
  assign bus.load_pending = load_pending_q;
  assign bus.dbg_cnt      = cnt_q;
  assign bus.dbg_dir      = dir_q;

endmodule

// File: tb/tb_pwm_multi_core.sv
// Bench for pwm_multi_core: directed scenarios plus random traffic against a period-phase model.
module tb_pwm_multi_core;
  import pwm_pkg::*;

  localparam int CH = 4;
  localparam int CW = 16;
  localparam int PW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pwm_multi_core_if #(.CHANNELS(CH), .CNT_W(CW), .PRESC_W(PW)) bus ();

  pwm_multi_core #(.CHANNELS(CH), .CNT_W(CW), .PRESC_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  // Reference: position k within the current period; cnt derived from k by plain arithmetic.
  int m_presc, m_k, a_p, p_p;
  int a_d[CH];
  int p_d[CH];
  bit a_m, p_m, m_lp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int len_of(input int p, input bit m);
    if (p == 0) return 1;
    return m ? 2 * p : p + 1;
  endfunction

  function automatic int cnt_of(input int k, input int p, input bit m);
    if (m && k > p) return 2 * p - k;
    return k;
  endfunction

  task automatic take_active();
    a_p = int'(bus.period);
    a_m = bus.center_mode;
    for (int i = 0; i < CH; i++) a_d[i] = int'(bus.duty[i*CW +: CW]);
  endtask

  task automatic model_step();
    logic [CH-1:0] raw, pwm_e;
    bit tk, bnd;
    int c;
    bnd = 1'b0;
    if (reset) begin
      m_presc = 0; m_k = 0; a_p = 0; p_p = 0; a_m = 0; p_m = 0; m_lp = 0;
      for (int i = 0; i < CH; i++) begin a_d[i] = 0; p_d[i] = 0; end
      pwm_e = '0;
    end else begin
      c = cnt_of(m_k, a_p, a_m);
      for (int i = 0; i < CH; i++) raw[i] = (c < a_d[i]);
      pwm_e = bus.enable ? (raw ^ bus.polarity) : bus.polarity;
      if (!bus.enable) begin
        m_presc = 0;
        m_k = 0;
        if (bus.load) begin take_active(); m_lp = 0; end
      end else begin
        tk = (m_presc >= int'(bus.prescale));
        m_presc = tk ? 0 : m_presc + 1;
        bnd = tk && (m_k == len_of(a_p, a_m) - 1);
        if (tk) m_k = bnd ? 0 : m_k + 1;
        if (bnd) begin
          if (bus.load) take_active();
          else if (m_lp) begin
            a_p = p_p; a_m = p_m;
            for (int i = 0; i < CH; i++) a_d[i] = p_d[i];
          end
          m_lp = 0;
        end else if (bus.load) begin
          p_p = int'(bus.period);
          p_m = bus.center_mode;
          for (int i = 0; i < CH; i++) p_d[i] = int'(bus.duty[i*CW +: CW]);
          m_lp = 1;
        end
      end
    end
    exp_q.push_back({2'b00, m_lp, bnd, pwm_e});
  endtask

  task automatic check_all();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("pwm_out", 32'(bus.pwm_out), 32'(e[3:0]));
      check("period_tick", 32'(bus.period_tick), 32'(e[4]));
      check("load_pending", 32'(bus.load_pending), 32'(e[5]));
    end
    check("cnt", 32'(bus.dbg_cnt), 32'(cnt_of(m_k, a_p, a_m)));
    check("dir", 32'(bus.dbg_dir), (a_m && a_p > 0 && m_k > a_p) ? 32'd1 : 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic load_cfg(input int p, input logic [CH*CW-1:0] d, input bit m);
    bus.period      = CW'(p);
    bus.duty        = d;
    bus.center_mode = m;
    bus.load        = 1'b1;
    step(1);
    bus.load        = 1'b0;
  endtask

  task automatic measure(input int n, input int ch, output int highs, output int ticks);
    highs = 0;
    ticks = 0;
    for (int j = 0; j < n; j++) begin
      step(1);
      highs += int'(bus.pwm_out[ch]);
      ticks += int'(bus.period_tick);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (bus.period_tick !== 1'b1 && n < 60) begin
      step(1);
      n++;
    end
    if (n >= 60) check("wait_tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic rand_cfg();
    int p;
    p = $urandom_range(0, 12);
    bus.period = CW'(p);
    for (int i = 0; i < CH; i++) bus.duty[i*CW +: CW] = CW'($urandom_range(0, p + 2));
    bus.center_mode = 1'($urandom_range(0, 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int h, t;
    reset           = 1'b1;
    bus.enable      = 1'b0;
    bus.prescale    = '0;
    bus.period      = '0;
    bus.duty        = '0;
    bus.center_mode = 1'b0;
    bus.polarity    = '0;
    bus.load        = 1'b0;
    step(3);
    check("rst_pwm", 32'(bus.pwm_out), 32'd0);
    check("rst_lp", 32'(bus.load_pending), 32'd0);
    check("rst_tick", 32'(bus.period_tick), 32'd0);
    reset = 1'b0;

    // Edge mode P=9: ch0 D=3, ch1 D=0, ch2 D=10, ch3 D=0; loaded while disabled.
    load_cfg(9, {16'd0, 16'd10, 16'd0, 16'd3}, MODE_EDGE);
    bus.enable = 1'b1;
    step(20);
    measure(30, 0, h, t);
    check("t1_high", 32'(h), 32'd9);
    check("t1_ticks", 32'(t), 32'd3);
    measure(20, 1, h, t);
    check("t2_d0_high", 32'(h), 32'd0);
    measure(20, 2, h, t);
    check("t2_d10_high", 32'(h), 32'd20);
    bus.polarity = 4'b1111;
    step(2);
    measure(20, 1, h, t);
    check("t2_d0_inv", 32'(h), 32'd20);
    measure(20, 2, h, t);
    check("t2_d10_inv", 32'(h), 32'd0);
    measure(20, 0, h, t);
    check("t2_d3_inv", 32'(h), 32'd14);
    bus.enable = 1'b0;
    step(2);
    measure(5, 0, h, t);
    check("t2_dis_pol", 32'(h), 32'd5);
    bus.polarity = 4'b0000;
    step(2);
    measure(5, 0, h, t);
    check("t2_dis_nopol", 32'(h), 32'd0);
    bus.enable = 1'b1;
    step(12);

    // Centre mode P=4, D=2.
    load_cfg(4, {16'd0, 16'd0, 16'd0, 16'd2}, MODE_CENTER);
    step(30);
    measure(16, 0, h, t);
    check("t3_high", 32'(h), 32'd6);
    check("t3_ticks", 32'(t), 32'd2);

    // Mid-period reload, then a reload landing on the boundary cycle.
    load_cfg(9, {16'd0, 16'd0, 16'd0, 16'd3}, MODE_EDGE);
    step(30);
    wait_tick();
    step(3);
    load_cfg(9, {16'd0, 16'd0, 16'd0, 16'd7}, MODE_EDGE);
    check("t4_lp_set", 32'(bus.load_pending), 32'd1);
    step(15);
    measure(10, 0, h, t);
    check("t4_new_high", 32'(h), 32'd7);
    wait_tick();
    step(9);
    load_cfg(9, {16'd0, 16'd0, 16'd0, 16'd5}, MODE_EDGE);
    check("t4_bnd_lp", 32'(bus.load_pending), 32'd0);
    check("t4_bnd_tick", 32'(bus.period_tick), 32'd1);
    measure(10, 0, h, t);
    check("t4_bnd_high", 32'(h), 32'd5);

    // Prescale 3, P=1 -> 8 clk period; enable gap and restart.
    bus.prescale = 8'd3;
    load_cfg(1, {16'd0, 16'd0, 16'd0, 16'd1}, MODE_EDGE);
    step(40);
    measure(32, 0, h, t);
    check("t5_ticks", 32'(t), 32'd4);
    check("t5_high", 32'(h), 32'd16);
    bus.enable   = 1'b0;
    bus.polarity = 4'b0101;
    step(5);
    check("t5_dis_cnt", 32'(bus.dbg_cnt), 32'd0);
    check("t5_dis_pwm", 32'(bus.pwm_out), 32'h5);
    bus.polarity = 4'b0000;
    bus.enable   = 1'b1;
    measure(7, 0, h, t);
    check("t5_restart_quiet", 32'(t), 32'd0);
    step(1);
    check("t5_first_tick", 32'(bus.period_tick), 32'd1);

    // Reset while a set is pending.
    bus.prescale = 8'd0;
    load_cfg(9, {16'd0, 16'd0, 16'd0, 16'd3}, MODE_EDGE);
    step(25);
    wait_tick();
    step(3);
    load_cfg(5, {16'd1, 16'd1, 16'd1, 16'd1}, MODE_CENTER);
    check("t6_lp_before", 32'(bus.load_pending), 32'd1);
    reset = 1'b1;
    step(1);
    check("t6_pwm", 32'(bus.pwm_out), 32'd0);
    check("t6_lp", 32'(bus.load_pending), 32'd0);
    reset = 1'b0;
    step(10);
    measure(10, 0, h, t);
    check("t6_no_apply", 32'(h), 32'd0);
    check("t6_p0_ticks", 32'(t), 32'd10);

    // Random traffic.
    for (int it = 0; it < 60; it++) begin
      for (int c = 0; c < 30; c++) begin
        reset      = ($urandom_range(0, 59) == 0);
        bus.enable = ($urandom_range(0, 19) != 0);
        bus.load   = ($urandom_range(0, 7) == 0);
        if (bus.load) rand_cfg();
        if ($urandom_range(0, 29) == 0) bus.prescale = PW'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) bus.polarity = CH'($urandom);
        step(1);
      end
    end
    reset    = 1'b0;
    bus.load = 1'b0;
    step(2);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
